// File: rtl/posit_div.sv
// posit_div -- iterative posit divider, out = in1 / in2.
//
// Decodes both operands, runs one non-restoring quotient bit per clock,
// normalises, then rounds round-to-nearest-even back into a posit.
// Uses the same start/done and inf/zero flag scheme as the multiplier.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   in1    : dividend posit, captured when start is accepted
//   in2    : divisor posit, captured when start is accepted
//   start  : request, accepted only while idle
//   out    : quotient posit, held until the next result
//   inf    : result is NaR
//   zero   : result is zero
//   done   : one-cycle pulse when out/inf/zero are valid
//   busy   : high from the cycle after acceptance through the done cycle
//
// Build option
//   POSIT_DIV_EARLY_OUT_EN : NaR / divide-by-zero / zero-dividend results
//                            skip DIVIDE and NORM (done two cycles after
//                            acceptance). Undefined: fixed Q+3 latency.

module posit_div #(
  parameter int N  = 16,
  parameter int es = 3,
  parameter int Bs = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         start,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         zero,
  output logic         done,
  output logic         busy
);

  localparam int M  = N - es;                      // mantissa {1, frac}
  localparam int Q  = N - es + 3;                  // quotient bits / iterations
  localparam int RW = N - es + 2;                  // partial remainder width
  localparam int KW = Bs + 1;                      // signed regime count
  localparam int SW = Bs + es + 2;                 // signed scale
  localparam int CW = $clog2(Q);
  localparam int VW = 2 + es + (Q - 1) + (N - 1);  // pre-rounding bit string

  localparam logic [N-1:0]         NAR   = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [SW-1:0] K_MAX = SW'(N - 2);
  localparam logic signed [SW-1:0] K_MIN = SW'(2 - N);

  typedef enum logic [2:0] {IDLE, DECODE, DIVIDE, NORM, ROUND} state_t;

  typedef struct packed {
    logic                 sgn;
    logic signed [KW-1:0] k;
    logic [es-1:0]        e;
    logic [M-1:0]         m;
  } dec_t;

  // Sign, regime, exponent and {1, fraction} of one posit operand.
  function automatic dec_t decode(input logic [N-1:0] p);
    dec_t         d;
    logic [N-2:0] body;
    logic [N-2:0] sh;
    logic         lead;
    logic         stop;
    int unsigned  run;
    body = p[N-1] ? (N-1)'(-p) : p[N-2:0];
    lead = body[N-2];
    run  = 0;
    stop = 1'b0;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (!stop && body[N-2-i] == lead) run++;
      else stop = 1'b1;
    end
    // Drop the regime run and its terminator; exponent then fraction remain.
    sh    = body << (run + 1);
    d.sgn = p[N-1];
    d.k   = lead ? KW'(run - 1) : KW'(0 - run);
    d.e   = sh[N-2 -: es];
    d.m   = {1'b1, sh[N-2-es:0]};
    return d;
  endfunction

  state_t state, state_nx;

  logic [N-1:0]         a_r, b_r;
  logic [M-1:0]         m1_r, m2_r;
  logic                 sgn_r;
  logic signed [SW-1:0] scale_r;
  logic signed [RW-1:0] rem_r;
  logic [Q-1:0]         q_r;
  logic [CW-1:0]        cnt;

  dec_t                 d1, d2;
  logic                 spec_nar, spec_zero;
  logic signed [RW-1:0] d_ext, base, trial, rem_fix;
  logic                 sticky;
  logic [Q-2:0]         qfrac;
  logic signed [SW-1:0] scn, rk;
  logic [es-1:0]        re;
  logic                 rk_pos;
  logic [SW-1:0]        shamt;
  logic [VW-1:0]        vec, fill, vsh;
  logic [N-2:0]         mag, mag_rnd;
  logic                 g, r, s, ulp;
  logic [N-1:0]         rounded;
  logic [N-1:0]         res_out;
  logic                 res_inf, res_zero;
  logic                 load_res;

  always_comb begin
    d1 = decode(a_r);
    d2 = decode(b_r);
  end

  assign spec_nar  = (a_r == NAR) | (b_r == NAR) | (b_r == '0);
  assign spec_zero = (a_r == '0);

  // Non-restoring step. The register holds the un-doubled remainder, so its
  // sign selects add/subtract and the doubling happens here.
  always_comb begin
    d_ext = {2'b00, m2_r};
    base  = (cnt == '0) ? {2'b00, m1_r} : {rem_r[RW-2:0], 1'b0};
    trial = base[RW-1] ? base + d_ext : base - d_ext;
  end

  // Normalise and round combinationally during NORM; the result is
  // registered on the edge that enters ROUND so outputs move with done.
  always_comb begin
    rem_fix = rem_r[RW-1] ? rem_r + d_ext : rem_r;
    sticky  = |rem_fix;
    qfrac   = q_r[Q-1] ? q_r[Q-2:0] : {q_r[Q-3:0], 1'b0};
    scn     = q_r[Q-1] ? scale_r : scale_r - SW'(1);
    rk      = scn >>> es;
    re      = scn[es-1:0];
    rk_pos  = ~rk[SW-1];
    // k >= 0 : k+1 ones then 0  -> seed 2'b10, shift k, fill ones
    // k <  0 : -k zeros then 1  -> seed 2'b01, shift -k-1 (= ~k), fill zeros
    shamt   = rk_pos ? rk : ~rk;
    vec     = {(rk_pos ? 2'b10 : 2'b01), re, qfrac, {(N-1){1'b0}}};
    fill    = rk_pos ? ~({VW{1'b1}} >> shamt) : '0;
    vsh     = (vec >> shamt) | fill;
    mag     = vsh[VW-1 -: N-1];
    g       = vsh[VW-N];
    r       = vsh[VW-N-1];
    s       = (|vsh[VW-N-2:0]) | sticky;
    ulp     = (g & (r | s)) | (mag[0] & g & ~(r | s));
    mag_rnd = mag + {{(N-2){1'b0}}, ulp};
    if (rk >= K_MAX)     mag_rnd = '1;
    else if (rk < K_MIN) mag_rnd = {{(N-2){1'b0}}, 1'b1};
    rounded = sgn_r ? -{1'b0, mag_rnd} : {1'b0, mag_rnd};
  end

  always_comb begin
    res_out  = rounded;
    res_inf  = 1'b0;
    res_zero = 1'b0;
    if (spec_nar) begin
      res_out = NAR;
      res_inf = 1'b1;
    end else if (spec_zero) begin
      res_out  = '0;
      res_zero = 1'b1;
    end
  end

`ifdef POSIT_DIV_EARLY_OUT_EN
  assign load_res = (state == NORM) | ((state == DECODE) & (spec_nar | spec_zero));
`else
  assign load_res = (state == NORM);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = DECODE;
      DECODE: begin
`ifdef POSIT_DIV_EARLY_OUT_EN
        state_nx = (spec_nar | spec_zero) ? ROUND : DIVIDE;
`else
        state_nx = DIVIDE;
`endif
      end
      DIVIDE: if (cnt == CW'(Q - 1)) state_nx = NORM;
      NORM:   state_nx = ROUND;
      ROUND:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
    done = (state == ROUND);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      m1_r    <= '0;
      m2_r    <= '0;
      sgn_r   <= 1'b0;
      scale_r <= '0;
      rem_r   <= '0;
      q_r     <= '0;
      cnt     <= '0;
      out     <= '0;
      inf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_r <= in1;
        b_r <= in2;
      end
      if (state == DECODE) begin
        m1_r    <= d1.m;
        m2_r    <= d2.m;
        sgn_r   <= d1.sgn ^ d2.sgn;
        scale_r <= $signed({d1.k[KW-1], d1.k, d1.e}) - $signed({d2.k[KW-1], d2.k, d2.e});
        cnt     <= '0;
      end
      if (state == DIVIDE) begin
        rem_r <= trial;
        q_r   <= {q_r[Q-2:0], ~trial[RW-1]};
        cnt   <= cnt + CW'(1);
      end
      if (load_res) begin
        out  <= res_out;
        inf  <= res_inf;
        zero <= res_zero;
      end
    end
  end

endmodule
